buffer_register_n: RTL and testbench

BUFFER_REGISTER_N -- requirements
Module: buffer_register_n

---
 rtl/buffer_register_n.sv | 86 ++++++++
 tb/tb_buffer_register_n.sv | 136 +++++++++++++
 2 files changed

// File: rtl/buffer_register_n.sv
// buffer_register_n: two-channel sense/translator buffer register with optional odd-parity window checker.
// The checker is built only when BUFFER_REGISTER_N_PARITY_CHECK_EN is defined.
module buffer_register_n #(
  parameter int WIDTH        = 13,
  parameter int MODULES      = 8,
  parameter int SENSE_CYCLES = 3
) (
  input  logic                         SIM_CLK,
  input  logic                         SIM_RST,
  input  logic                         V1,
  input  logic [1:0]                   CBRVN,
  input  logic [1:0]                   PARV,
  input  logic [1:0]                   SBRXV,
  input  logic [2*WIDTH-1:0]           TRV,
  input  logic [MODULES*(WIDTH+1)-1:0] SA,
  output logic [WIDTH:0]               BRA,
  output logic [WIDTH:0]               BRAN,
  output logic [WIDTH:0]               BRB,
  output logic [WIDTH:0]               BRBN,
  output logic [1:0]                   PVALID,
  output logic [1:0]                   PERR
);
  logic [1:0][WIDTH:0] set_w, br_d, br_q;
  always_comb begin
    for (int c = 0; c < 2; c++)
      set_w[c] = {PARV[c], SBRXV[c] ? TRV[c*WIDTH +: WIDTH] : {WIDTH{1'b0}}};
    for (int m = 0; m < MODULES; m++)
      set_w[m % 2] = set_w[m % 2] | SA[m*(WIDTH+1) +: WIDTH+1];
    for (int c = 0; c < 2; c++)
      br_d[c] = {(WIDTH+1){V1}} & (set_w[c] | (br_q[c] & {(WIDTH+1){CBRVN[c]}}));
  end
  always_ff @(posedge SIM_CLK)
    if (SIM_RST) br_q <= '0;
    else br_q <= br_d;
  assign BRA  = br_q[0];
  assign BRAN = ~br_q[0];
  assign BRB  = br_q[1];
  assign BRBN = ~br_q[1];
`ifdef BUFFER_REGISTER_N_PARITY_CHECK_EN
  typedef enum logic [1:0] {IDLE, CLR, WIN, CHK} state_e;
  state_e     st_q [2], st_d [2];
  logic [3:0] cnt_q [2], cnt_d [2];
  logic [1:0] pv_q, pv_d, pe_q, pe_d;
  // A clear always wins over window progress; the strobe is registered out of CHK.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      st_d[c]  = st_q[c];
      cnt_d[c] = cnt_q[c];
      pv_d[c]  = V1 & CBRVN[c] & (st_q[c] == CHK);
      if (!V1) st_d[c] = IDLE;
      else if (!CBRVN[c]) st_d[c] = CLR;
      else
        case (st_q[c])
          CLR: begin
            st_d[c]  = WIN;
            cnt_d[c] = 4'(SENSE_CYCLES - 1);
          end
          WIN: begin
            st_d[c]  = cnt_q[c] == 4'd0 ? CHK : WIN;
            cnt_d[c] = cnt_q[c] == 4'd0 ? 4'd0 : cnt_q[c] - 4'd1;
          end
          CHK:     st_d[c] = IDLE;
          default: st_d[c] = IDLE;
        endcase
      pe_d[c] = (!V1 || st_d[c] == CLR) ? 1'b0 : pv_d[c] ? ~^br_q[c] : pe_q[c];
    end
  end
  always_ff @(posedge SIM_CLK)
    if (SIM_RST) begin
      st_q  <= '{IDLE, IDLE};
      cnt_q <= '{4'd0, 4'd0};
      pv_q  <= '0;
      pe_q  <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      pv_q  <= pv_d;
      pe_q  <= pe_d;
    end
  assign PVALID = pv_q;
  assign PERR   = pe_q;
`else
  assign PVALID = '0;
  assign PERR   = '0;
`endif
endmodule

// File: tb/tb_buffer_register_n.sv
// tb_buffer_register_n: random + directed bench against a window-timing reference model.
module tb_buffer_register_n;
  localparam int W = 13, M = 8, S = 3;
`ifdef BUFFER_REGISTER_N_PARITY_CHECK_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif
  logic clk = 1'b0, rst, v1;
  logic [1:0] cbrvn, parv, sbrxv, pvalid, perr;
  logic [2*W-1:0] trv;
  logic [M*(W+1)-1:0] sa;
  logic [W:0] bra, bran, brb, brbn;
  int checks = 0, errors = 0;
  bit chk_en = 1'b0;
  logic [W:0] mbr [2];
  int since [2];
  bit armed [2], mpv [2], mpe [2];

  buffer_register_n #(.WIDTH(W), .MODULES(M), .SENSE_CYCLES(S)) dut (
    .SIM_CLK(clk), .SIM_RST(rst), .V1(v1), .CBRVN(cbrvn), .PARV(parv), .SBRXV(sbrxv),
    .TRV(trv), .SA(sa), .BRA(bra), .BRAN(bran), .BRB(brb), .BRBN(brbn),
    .PVALID(pvalid), .PERR(perr));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W:0] model_br(int c);
    logic [W:0] s = {parv[c], sbrxv[c] ? trv[c*W +: W] : {W{1'b0}}};
    for (int m = c; m < M; m += 2) s |= sa[m*(W+1) +: W+1];
    return v1 ? (s | (cbrvn[c] ? mbr[c] : '0)) : '0;
  endfunction

  // since[c] counts edges after the release edge; the strobe lands on edge S+1.
  always @(posedge clk)
    for (int c = 0; c < 2; c++) begin
      mbr[c] <= rst ? '0 : model_br(c);
      if (rst || !v1) begin
        since[c] <= -1; armed[c] <= 1'b0; mpv[c] <= 1'b0; mpe[c] <= 1'b0;
      end else if (!cbrvn[c]) begin
        since[c] <= -1; armed[c] <= 1'b1; mpv[c] <= 1'b0; mpe[c] <= 1'b0;
      end else begin
        armed[c] <= 1'b0;
        since[c] <= armed[c] ? 0 : (since[c] >= 0 && since[c] < S) ? since[c] + 1 : -1;
        mpv[c]   <= since[c] == S;
        mpe[c]   <= since[c] == S ? ~^mbr[c] : mpe[c];
      end
    end

  always @(negedge clk)
    if (chk_en) begin
      chk("bra", bra, mbr[0]);
      chk("bran", bran, ~mbr[0]);
      chk("brb", brb, mbr[1]);
      chk("brbn", brbn, ~mbr[1]);
      chk("pvalid", {12'd0, pvalid}, PEN ? {12'd0, mpv[1], mpv[0]} : '0);
      chk("perr", {12'd0, perr}, PEN ? {12'd0, mpe[1], mpe[0]} : '0);
    end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic parity_run(input logic [W:0] word, input bit exp_err);
    cbrvn = 2'b01; tick;
    cbrvn = 2'b11; tick;
    sa[1*(W+1) +: W+1] = word; tick;
    sa = '0;
    tick; chk("pv_early1", {13'd0, pvalid[1]}, '0);
    tick; chk("pv_early2", {13'd0, pvalid[1]}, '0);
    tick; chk("pv_win", {13'd0, pvalid[1]}, {13'd0, PEN});
    chk("perr_win", {13'd0, perr[1]}, {13'd0, PEN & exp_err});
    chk("brb_word", brb, word);
    tick; chk("pv_after", {13'd0, pvalid[1]}, '0);
  endtask

  initial begin
    rst = 1'b1; v1 = 1'b0; cbrvn = 2'b11; parv = '0; sbrxv = '0; trv = '0; sa = '0;
    tick;
    chk_en = 1'b1;
    chk("rst_bra", bra, '0);
    chk("rst_bran", bran, 14'h3fff);
    chk("rst_pv", {12'd0, pvalid}, '0);
    rst = 1'b0; v1 = 1'b1;
    sa[2*(W+1) + 5] = 1'b1; tick;
    sa = '0;
    chk("sa_set_a", bra, 14'h0020);
    chk("sa_set_b", brb, '0);
    tick; chk("sa_hold_a", bra, 14'h0020);
    cbrvn = 2'b10; sa[3] = 1'b1; tick;
    sa = '0;
    chk("set_dominates", bra, 14'h0008);
    tick; chk("clear_a", bra, '0);
    cbrvn = 2'b11; sbrxv = 2'b10; trv = {13'h00A5, 13'h1fff}; tick;
    sbrxv = '0; trv = '0;
    chk("trv_b", brb, 14'h00A5);
    chk("trv_a_ignored", bra, '0);
    repeat (6) tick;
    parity_run(14'h0001, 1'b0);
    parity_run(14'h0003, 1'b1);
    cbrvn = 2'b10; tick;
    cbrvn = 2'b11; tick;
    tick;
    cbrvn = 2'b10; tick;
    cbrvn = 2'b11; tick;
    tick; chk("abort_pv", {12'd0, pvalid}, '0);
    chk("abort_perr", {12'd0, perr}, '0);
    sa[0 +: W+1] = 14'h0155; tick;
    sa = '0; rst = 1'b1; tick;
    rst = 1'b0;
    chk("midwin_rst_a", bra, '0);
    chk("midwin_rst_bn", brbn, 14'h3fff);
    chk("midwin_rst_pv", {12'd0, pvalid}, '0);
    repeat (4000) begin
      rst   = $urandom_range(199) == 0;
      v1    = $urandom_range(15) != 0;
      cbrvn = {$urandom_range(7) != 0, $urandom_range(7) != 0};
      parv  = {$urandom_range(15) == 0, $urandom_range(15) == 0};
      sbrxv = 2'($urandom);
      trv   = 26'($urandom);
      for (int m = 0; m < M; m++)
        sa[m*(W+1) +: W+1] = $urandom_range(7) == 0 ? 14'($urandom) : '0;
      tick;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
